lsu_rv32: RTL and testbench

Load/store unit serving the execute stage of the RV32 core: it accepts one memory request at a time from the EXU's load/store interface and drives a word-wide valid/ready memory bus with byte strobes. It returns zero- or sign-extended load data to the EXU through a held valid/ready response. It sits between the EXU and the data memory or bus bridge, and is the responder end of the EXU's `addr_load`/`ls_valid`/`ls_ready`/`load_data` interface.

---
 rtl/lsu_rv32_if.sv | 49 ++++
 rtl/lsu_rv32.sv | 183 ++++++++++++++++++
 tb/tb_lsu_rv32.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rv32_if.sv
// Bundle of the EXU request/response and memory bus signals of the LSU.
// The slave view is the LSU. The master view is the EXU plus memory side.
interface lsu_rv32_if #(
    parameter int DATA_LEN = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [DATA_LEN-1:0] req_addr;
    logic [DATA_LEN-1:0] req_wdata;
    logic                req_load;
    logic                req_store;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic                ls_valid;
    logic                ls_ready;
    logic [DATA_LEN-1:0] load_data;
    logic                resp_err;
    logic                mem_valid;
    logic                mem_ready;
    logic [DATA_LEN-1:0] mem_addr;
    logic                mem_wen;
    logic [3:0]          mem_wstrb;
    logic [DATA_LEN-1:0] mem_wdata;
    logic                mem_rvalid;
    logic [DATA_LEN-1:0] mem_rdata;
    logic                mem_rready;

    modport slave (
        input  req_valid, req_addr, req_wdata,
        input  req_load, req_store, req_size,
        input  req_unsigned, ls_ready,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, ls_valid, load_data,
        output resp_err, mem_valid, mem_addr,
        output mem_wen, mem_wstrb, mem_wdata,
        output mem_rready
    );

    modport master (
        output req_valid, req_addr, req_wdata,
        output req_load, req_store, req_size,
        output req_unsigned, ls_ready,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, ls_valid, load_data,
        input  resp_err, mem_valid, mem_addr,
        input  mem_wen, mem_wstrb, mem_wdata,
        input  mem_rready
    );
endinterface

// File: rtl/lsu_rv32.sv
// RV32 load/store unit: one request in flight, word bus with byte strobes,
// extended load data returned through a held valid/ready response.
module lsu_rv32 #(
    parameter int DATA_LEN = 32
) (
    input logic       clk,
    input logic       rst_n,
    lsu_rv32_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [DATA_LEN-1:0] mem_addr_q, mem_addr_d;
    logic                mem_wen_q, mem_wen_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic [DATA_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_LEN-1:0] load_data_q, load_data_d;
    logic                resp_err_q, resp_err_d;

    logic                is_byte, is_half, is_word;
    logic                misaligned;
    logic [3:0]          strb;
    logic [DATA_LEN-1:0] rep_wdata;
    logic [7:0]          byte_l;
    logic [15:0]         half_l;
    logic                sgn;
    logic [DATA_LEN-1:0] ext_data;

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_valid  = (state_q == REQ);
    assign bus.mem_rready = (state_q == WAIT_R);
    assign bus.ls_valid   = (state_q == RESP);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.load_data  = load_data_q;
    assign bus.resp_err   = resp_err_q;

    assign is_byte = (bus.req_size == 2'b00);
    assign is_half = (bus.req_size == 2'b01);
    assign is_word = bus.req_size[1];

    assign misaligned = (is_half && bus.req_addr[0])
                     || (is_word && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        strb      = 4'b0000;
        rep_wdata = '0;
        unique case (1'b1)
            is_byte: begin
                strb      = 4'b0001 << bus.req_addr[1:0];
                rep_wdata = {4{bus.req_wdata[7:0]}};
            end
            is_half: begin
                strb      = 4'b0011 << {bus.req_addr[1], 1'b0};
                rep_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                rep_wdata = bus.req_wdata;
            end
        endcase
    end

    // Lane select uses the byte offset captured at acceptance.
    always_comb begin
        byte_l = bus.mem_rdata[7:0];
        unique case (addr_lo_q)
            2'b00: byte_l = bus.mem_rdata[7:0];
            2'b01: byte_l = bus.mem_rdata[15:8];
            2'b10: byte_l = bus.mem_rdata[23:16];
            2'b11: byte_l = bus.mem_rdata[31:24];
            default: byte_l = bus.mem_rdata[7:0];
        endcase
    end

    assign half_l = addr_lo_q[1] ? bus.mem_rdata[31:16]
                                 : bus.mem_rdata[15:0];

    always_comb begin
        sgn      = 1'b0;
        ext_data = bus.mem_rdata;
        unique case (1'b1)
            (size_q == 2'b00): begin
                sgn      = ~uns_q & byte_l[7];
                ext_data = {{24{sgn}}, byte_l};
            end
            (size_q == 2'b01): begin
                sgn      = ~uns_q & half_l[15];
                ext_data = {{16{sgn}}, half_l};
            end
            default: ext_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        load_data_d = load_data_q;
        resp_err_d  = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_lo_d   = bus.req_addr[1:0];
                    size_d      = bus.req_size;
                    uns_d       = bus.req_unsigned;
                    mem_addr_d  = {bus.req_addr[DATA_LEN-1:2], 2'b00};
                    mem_wen_d   = bus.req_store;
                    mem_wstrb_d = bus.req_store ? strb : 4'b0000;
                    mem_wdata_d = bus.req_store ? rep_wdata : '0;
                    load_data_d = '0;
                    resp_err_d  = 1'b0;
                    if (!(bus.req_store || bus.req_load)) begin
                        state_d = RESP;
                    end else if (misaligned) begin
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    state_d = mem_wen_q ? RESP : WAIT_R;
                end
            end
            WAIT_R: begin
                if (bus.mem_rvalid) begin
                    load_data_d = ext_data;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.ls_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_lo_q   <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
            load_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
            resp_err_q  <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_lsu_rv32.sv
// Directed bench for lsu_rv32 with hand-computed expected values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lsu_rv32;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lsu_rv32_if #(.DATA_LEN(32)) bus ();

    lsu_rv32 #(.DATA_LEN(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_load     = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.ls_ready     = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = '0;
    endtask

    task automatic put_req(input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input logic ld, input logic st,
                           input logic [1:0] size,
                           input logic uns);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_load     = ld;
        bus.req_store    = st;
        bus.req_size     = size;
        bus.req_unsigned = uns;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, ".ls_valid"}, 32'(bus.ls_valid), 32'd0);
        check({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd0);
        check({tag, ".mem_rready"}, 32'(bus.mem_rready), 32'd0);
        check({tag, ".mem_wen"}, 32'(bus.mem_wen), 32'd0);
        check({tag, ".resp_err"}, 32'(bus.resp_err), 32'd0);
        check({tag, ".load_data"}, bus.load_data, 32'd0);
        check({tag, ".mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        check({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    // Load with mem_ready at cycle 1 and mem_rvalid at cycle 2.
    task automatic do_load(input string tag,
                           input logic [31:0] addr,
                           input logic [1:0] size,
                           input logic uns,
                           input logic [31:0] rdata,
                           input logic [31:0] exp);
        put_req(addr, 32'h0, 1'b1, 1'b0, size, uns);
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        check({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd1);
        check({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        check({tag, ".mem_wen"}, 32'(bus.mem_wen), 32'd0);
        check({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        tick();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        check({tag, ".mem_rready"}, 32'(bus.mem_rready), 32'd1);
        check({tag, ".ls_valid_c2"}, 32'(bus.ls_valid), 32'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        bus.ls_ready   = 1'b1;
        check({tag, ".ls_valid"}, 32'(bus.ls_valid), 32'd1);
        check({tag, ".load_data"}, bus.load_data, exp);
        check({tag, ".resp_err"}, 32'(bus.resp_err), 32'd0);
        tick();
        bus.ls_ready = 1'b0;
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    // Misaligned or null request: response at cycle 1, no bus access.
    task automatic do_short(input string tag,
                            input logic [31:0] addr,
                            input logic ld, input logic st,
                            input logic [1:0] size,
                            input logic err);
        put_req(addr, 32'h1234_5678, ld, st, size, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        bus.ls_ready  = 1'b1;
        check({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd0);
        check({tag, ".ls_valid"}, 32'(bus.ls_valid), 32'd1);
        check({tag, ".resp_err"}, 32'(bus.resp_err), 32'(err));
        check({tag, ".load_data"}, bus.load_data, 32'd0);
        tick();
        bus.ls_ready = 1'b0;
        check({tag, ".mem_valid_c2"}, 32'(bus.mem_valid), 32'd0);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();
        check_reset("post_rst");

        // Store byte, mem_ready already high before acceptance.
        put_req(32'h8000_0003, 32'h0000_00A5, 1'b0, 1'b1, 2'b00, 1'b0);
        bus.mem_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("sb.mem_valid", 32'(bus.mem_valid), 32'd1);
        check("sb.mem_addr", bus.mem_addr, 32'h8000_0000);
        check("sb.mem_wstrb", 32'(bus.mem_wstrb), 32'b1000);
        check("sb.mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        check("sb.mem_wen", 32'(bus.mem_wen), 32'd1);
        check("sb.ls_valid_c1", 32'(bus.ls_valid), 32'd0);
        tick();
        bus.mem_ready = 1'b0;
        bus.ls_ready  = 1'b1;
        check("sb.ls_valid", 32'(bus.ls_valid), 32'd1);
        check("sb.mem_valid_c2", 32'(bus.mem_valid), 32'd0);
        check("sb.load_data", bus.load_data, 32'd0);
        check("sb.resp_err", 32'(bus.resp_err), 32'd0);
        tick();
        bus.ls_ready = 1'b0;

        do_load("lb", 32'h8000_0002, 2'b00, 1'b0,
                32'h1280_FF34, 32'hFFFF_FF80);
        do_load("lbu", 32'h8000_0002, 2'b00, 1'b1,
                32'h1280_FF34, 32'h0000_0080);
        do_load("lh", 32'h8000_0002, 2'b01, 1'b0,
                32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu", 32'h8000_0002, 2'b01, 1'b1,
                32'h8001_1234, 32'h0000_8001);
        do_load("lw", 32'h8000_0004, 2'b10, 1'b0,
                32'h8001_1234, 32'h8001_1234);
        do_load("lb3", 32'h8000_0003, 2'b00, 1'b0,
                32'h7F00_0000, 32'h0000_007F);

        do_short("lw_mis", 32'h8000_0001, 1'b1, 1'b0, 2'b10, 1'b1);
        do_short("sh_mis", 32'h8000_0003, 1'b0, 1'b1, 2'b01, 1'b1);
        do_short("null", 32'h8000_0000, 1'b0, 1'b0, 2'b10, 1'b0);

        // Half store with mem_ready low for 3 cycles; stray rvalid in REQ.
        put_req(32'h8000_0012, 32'h0000_BEEF, 1'b0, 1'b1, 2'b01, 1'b0);
        tick();
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp.mem_valid", 32'(bus.mem_valid), 32'd1);
            check("bp.mem_addr", bus.mem_addr, 32'h8000_0010);
            check("bp.mem_wstrb", 32'(bus.mem_wstrb), 32'b1100);
            check("bp.mem_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
            check("bp.ls_valid", 32'(bus.ls_valid), 32'd0);
            tick();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_ready  = 1'b1;
        check("bp.mem_valid_last", 32'(bus.mem_valid), 32'd1);
        tick();
        bus.mem_ready = 1'b0;
        bus.ls_ready  = 1'b1;
        check("bp.resp", 32'(bus.ls_valid), 32'd1);
        check("bp.mem_rready", 32'(bus.mem_rready), 32'd0);
        tick();
        bus.ls_ready = 1'b0;

        // Byte load with rvalid delayed 4 cycles, then ls_ready low 2 cycles.
        put_req(32'h8000_0001, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0000_AB00;
        for (int i = 0; i < 4; i++) begin
            check("rd.mem_rready", 32'(bus.mem_rready), 32'd1);
            check("rd.ls_valid", 32'(bus.ls_valid), 32'd0);
            tick();
        end
        bus.mem_rvalid = 1'b1;
        check("rd.mem_rready_last", 32'(bus.mem_rready), 32'd1);
        tick();
        bus.mem_rvalid = 1'b0;
        put_req(32'h8000_0020, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("lr.ls_valid", 32'(bus.ls_valid), 32'd1);
            check("lr.load_data", bus.load_data, 32'h0000_00AB);
            check("lr.req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.ls_ready  = 1'b1;
        check("lr.ls_valid_last", 32'(bus.ls_valid), 32'd1);
        tick();
        bus.ls_ready = 1'b0;
        check("lr.idle", 32'(bus.req_ready), 32'd1);
        check("lr.no_accept", 32'(bus.mem_valid), 32'd0);

        // Reset pulse while in WAIT_R, then a stray rvalid.
        put_req(32'h8000_0004, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("wr.mem_rready", 32'(bus.mem_rready), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("wr_rst");
        tick();
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        tick();
        tick();
        bus.mem_rvalid = 1'b0;
        check_reset("wr_stray");

        put_req(32'h8000_0008, 32'h1122_3344, 1'b1, 1'b1, 2'b10, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        check("sw.mem_valid", 32'(bus.mem_valid), 32'd1);
        check("sw.mem_addr", bus.mem_addr, 32'h8000_0008);
        check("sw.mem_wen", 32'(bus.mem_wen), 32'd1);
        check("sw.mem_wstrb", 32'(bus.mem_wstrb), 32'b1111);
        check("sw.mem_wdata", bus.mem_wdata, 32'h1122_3344);
        tick();
        bus.mem_ready = 1'b0;
        bus.ls_ready  = 1'b1;
        check("sw.ls_valid", 32'(bus.ls_valid), 32'd1);
        check("sw.resp_err", 32'(bus.resp_err), 32'd0);
        check("sw.load_data", bus.load_data, 32'd0);
        tick();
        bus.ls_ready = 1'b0;
        check("sw.idle", 32'(bus.req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
